// File: rtl/a2d_rr_seq.sv
// Round-robin A2D sequencer: select/read SPI pair per nxt request, rotating lft -> rght -> batt.
// Optional LD_AVG_EN: two-sample averaging on lft_ld/rght_ld (batt always raw).
module a2d_rr_seq #(
  parameter logic [2:0] LFT_CH  = 3'd0,
  parameter logic [2:0] RGHT_CH = 3'd4,
  parameter logic [2:0] BATT_CH = 3'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SEL, GAP, READ} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  ptr_eff;
  logic [2:0]  ch_sel;
  logic        wrt_q, wrt_d;
  logic [15:0] cmd_q, cmd_d;
  logic [11:0] lft_q, lft_d;
  logic [11:0] rght_q, rght_d;
  logic [11:0] batt_q, batt_d;
  logic        cnv_q, cnv_d;
  logic [11:0] lft_new, rght_new;

`ifdef LD_AVG_EN
  logic        lft_first_q, lft_first_d;
  logic        rght_first_q, rght_first_d;
  logic [12:0] lft_sum, rght_sum;

  always_comb begin
    lft_sum  = {1'b0, lft_q}  + {1'b0, rd_data[11:0]};
    rght_sum = {1'b0, rght_q} + {1'b0, rd_data[11:0]};
    lft_new  = lft_first_q  ? rd_data[11:0] : lft_sum[12:1];
    rght_new = rght_first_q ? rd_data[11:0] : rght_sum[12:1];
  end
`else
  always_comb begin
    lft_new  = rd_data[11:0];
    rght_new = rd_data[11:0];
  end
`endif

  // Unreachable pointer value 3 behaves exactly like LFT.
  always_comb begin
    ptr_eff = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
    case (ptr_eff)
      2'd1:    ch_sel = RGHT_CH;
      2'd2:    ch_sel = BATT_CH;
      default: ch_sel = LFT_CH;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    lft_d   = lft_q;
    rght_d  = rght_q;
    batt_d  = batt_q;
    cnv_d   = 1'b0;
`ifdef LD_AVG_EN
    lft_first_d  = lft_first_q;
    rght_first_d = rght_first_q;
`endif
    case (state_q)
      IDLE: begin
        if (nxt) begin
          wrt_d   = 1'b1;
          cmd_d   = {2'b00, ch_sel, 11'h000};
          state_d = SEL;
        end
      end
      SEL: begin
        if (done) state_d = GAP;
      end
      GAP: begin
        wrt_d   = 1'b1;
        state_d = READ;
      end
      READ: begin
        if (done) begin
          cnv_d   = 1'b1;
          state_d = IDLE;
          case (ptr_eff)
            2'd1: begin
              rght_d = rght_new;
`ifdef LD_AVG_EN
              rght_first_d = 1'b0;
`endif
            end
            2'd2: batt_d = rd_data[11:0];
            default: begin
              lft_d = lft_new;
`ifdef LD_AVG_EN
              lft_first_d = 1'b0;
`endif
            end
          endcase
          ptr_d = (ptr_eff == 2'd2) ? 2'd0 : ptr_eff + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      wrt_q   <= 1'b0;
      cmd_q   <= '0;
      lft_q   <= '0;
      rght_q  <= '0;
      batt_q  <= '0;
      cnv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      batt_q  <= batt_d;
      cnv_q   <= cnv_d;
    end
  end

`ifdef LD_AVG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_first_q  <= 1'b1;
      rght_first_q <= 1'b1;
    end else begin
      lft_first_q  <= lft_first_d;
      rght_first_q <= rght_first_d;
    end
  end
`endif

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign batt      = batt_q;
  assign cnv_cmplt = cnv_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_a2d_rr_seq.sv
// Directed bench for a2d_rr_seq with a behavioural SPI master model (fixed done latency).
module tb_a2d_rr_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, batt;
  logic        cnv_cmplt, busy;

  logic        spi_done = 1'b0;
  logic [15:0] spi_data = '0;
  logic        man_done = 1'b0;
  logic [15:0] man_data = '0;
  assign done    = spi_done | man_done;
  assign rd_data = man_done ? man_data : spi_data;

  a2d_rr_seq #(.LFT_CH(3'd0), .RGHT_CH(3'd4), .BATT_CH(3'd5)) dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
    .cnv_cmplt(cnv_cmplt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  always @(posedge clk) ncyc++;

  logic        spi_en = 1'b1;
  int          spi_lat = 3;
  logic [15:0] rd_val = '0;
  int          cnt = 0;
  bit          phase = 0;
  bit          wrt_prev = 0;
  int          done_t = 0, sel_t = 0, cnv_t = 0;
  int          wrt_cnt = 0, cnv_cnt = 0, gap_err = 0, wrt_long = 0;
  logic [15:0] sel_cmd = '0, rd_cmd = '0;

  // SPI master model: done arrives spi_lat cycles after wrt; select read-back is junk.
  always @(negedge clk) begin
    spi_done = 1'b0;
    if (!spi_en) begin
      cnt = 0;
      phase = 0;
    end else if (cnt != 0) begin
      cnt--;
      if (cnt == 0) begin
        spi_done = 1'b1;
        spi_data = phase ? rd_val : 16'hA5A5;
        if (!phase) done_t = ncyc;
        phase = !phase;
      end
    end else if (wrt) begin
      wrt_cnt++;
      if (!phase) begin
        sel_cmd = cmd;
        sel_t = ncyc;
      end else begin
        rd_cmd = cmd;
        if (ncyc - done_t != 2) gap_err++;
      end
      cnt = spi_lat;
    end
    if (wrt && wrt_prev) wrt_long++;
    wrt_prev = wrt;
    if (cnv_cmplt) begin
      cnv_cnt++;
      cnv_t = ncyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cnv(input int c0);
    int n = 0;
    while (cnv_cnt == c0 && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) chk("cnv_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wrt"}, wrt, 0);
    chk({tag, "_cmd"}, cmd, 0);
    chk({tag, "_lft"}, lft_ld, 0);
    chk({tag, "_rght"}, rght_ld, 0);
    chk({tag, "_batt"}, batt, 0);
    chk({tag, "_cnv"}, cnv_cmplt, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_conv(input logic [15:0] v, input logic [2:0] ch);
    int c0, w0, t0;
    rd_val = v;
    c0 = cnv_cnt;
    w0 = wrt_cnt;
    step();
    nxt = 1'b1;
    t0 = ncyc;
    step();
    nxt = 1'b0;
    wait_cnv(c0);
    chk("sel_cmd", sel_cmd, {2'b00, ch, 11'h000});
    chk("rd_cmd", rd_cmd, {2'b00, ch, 11'h000});
    chk("latency", cnv_t - t0, 2 * spi_lat + 4);
    chk("wrt_pair", wrt_cnt - w0, 2);
  endtask

  typedef struct {
    logic [15:0] rd;
    logic [2:0]  ch;
    logic [11:0] lft;
    logic [11:0] rght;
    logic [11:0] bat;
  } vec_t;

  vec_t vt[7];

  initial begin
    int c0, w0;
    logic [15:0] hv[4];
    int n;

    vt[0] = '{16'hFABC, 3'd0, 12'hABC, 12'h000, 12'h000};
    vt[1] = '{16'hF456, 3'd4, 12'hABC, 12'h456, 12'h000};
    vt[2] = '{16'h0789, 3'd5, 12'hABC, 12'h456, 12'h789};
`ifdef LD_AVG_EN
    vt[3] = '{16'h0100, 3'd0, 12'h5DE, 12'h456, 12'h789};
    vt[4] = '{16'h0201, 3'd4, 12'h5DE, 12'h32B, 12'h789};
    vt[5] = '{16'h0FFF, 3'd5, 12'h5DE, 12'h32B, 12'hFFF};
    vt[6] = '{16'h0FFF, 3'd0, 12'hAEE, 12'h32B, 12'hFFF};
`else
    vt[3] = '{16'h0100, 3'd0, 12'h100, 12'h456, 12'h789};
    vt[4] = '{16'h0201, 3'd4, 12'h100, 12'h201, 12'h789};
    vt[5] = '{16'h0FFF, 3'd5, 12'h100, 12'h201, 12'hFFF};
    vt[6] = '{16'h0FFF, 3'd0, 12'hFFF, 12'h201, 12'hFFF};
`endif

    repeat (3) step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      spi_lat = (i % 2 == 0) ? 3 : 1;
      c0 = cnv_cnt;
      run_conv(vt[i].rd, vt[i].ch);
      chk("tbl_cnv_once", cnv_cnt - c0, 1);
      chk("tbl_lft", lft_ld, vt[i].lft);
      chk("tbl_rght", rght_ld, vt[i].rght);
      chk("tbl_batt", batt, vt[i].bat);
    end

    // nxt pulses while busy must be dropped
    spi_lat = 4;
    rd_val = 16'h0321;
    c0 = cnv_cnt;
    w0 = wrt_cnt;
    step();
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    chk("busy_sel", busy, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      nxt = (i % 2 == 0);
    end
    nxt = 1'b0;
    repeat (20) step();
    chk("ign_cnv", cnv_cnt - c0, 1);
    chk("ign_wrt", wrt_cnt - w0, 2);
    chk("ign_busy", busy, 0);
    chk("ign_cmd", sel_cmd, 16'h2000);
`ifdef LD_AVG_EN
    chk("ign_rght", rght_ld, 12'h326);
`else
    chk("ign_rght", rght_ld, 12'h321);
`endif

    // nxt held high: back-to-back round robin from a fresh reset
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    spi_lat = 2;
    hv[0] = 16'h0111; hv[1] = 16'h0222; hv[2] = 16'h0333; hv[3] = 16'h0444;
    w0 = wrt_cnt;
    c0 = cnv_cnt;
    rd_val = hv[0];
    step();
    nxt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_cnv(c0 + k);
      if (k == 3) nxt = 1'b0;
      if (k == 2) chk("hold_lft_mid", lft_ld, 12'h111);
      if (k < 3) begin
        n = cnv_t;
        rd_val = hv[k + 1];
        step();
        chk("hold_b2b", sel_t - n, 1);
      end
    end
    repeat (10) step();
    chk("hold_cnv", cnv_cnt - c0, 4);
    chk("hold_wrt", wrt_cnt - w0, 8);
    chk("hold_cmd4", sel_cmd, 16'h0000);
`ifdef LD_AVG_EN
    chk("hold_lft", lft_ld, 12'h2AA);
`else
    chk("hold_lft", lft_ld, 12'h444);
`endif
    chk("hold_rght", rght_ld, 12'h222);
    chk("hold_batt", batt, 12'h333);
    chk("hold_idle", busy, 0);

    // reset during READ, then a stray done
    spi_lat = 5;
    rd_val = 16'h0EEE;
    w0 = wrt_cnt;
    step();
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    n = 0;
    while (wrt_cnt - w0 < 2 && n < 100) begin
      step();
      n++;
    end
    chk("rst_reach_read", wrt_cnt - w0, 2);
    step();
    rst_n = 1'b0;
    spi_en = 1'b0;
    #1;
    check_zero("midrst");
    c0 = cnv_cnt;
    step();
    rst_n = 1'b1;
    step();
    man_data = 16'hFFFF;
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    repeat (4) step();
    chk("stray_cnv", cnv_cnt - c0, 0);
    check_zero("stray");
    spi_en = 1'b1;
    spi_lat = 2;

    run_conv(16'h0100, 3'd0);
    chk("post_lft1", lft_ld, 12'h100);
    run_conv(16'h0555, 3'd4);
    run_conv(16'h0666, 3'd5);
    run_conv(16'h0201, 3'd0);
`ifdef LD_AVG_EN
    chk("post_lft2", lft_ld, 12'h180);
`else
    chk("post_lft2", lft_ld, 12'h201);
`endif
    chk("post_rght", rght_ld, 12'h555);
    chk("post_batt", batt, 12'h666);

    chk("gap_err", gap_err, 0);
    chk("wrt_width", wrt_long, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/a2d_rr_seq.md
Name: a2d_rr_seq

Overview:
- Round-robin A2D conversion sequencer. Sits directly upstream of the steering-enable/balance logic and supplies its 12-bit lft_ld and rght_ld load-cell values.
- Also supplies the battery reading.
- Drives an existing 16-bit SPI master through a wrt/done handshake.
- Each conversion costs two SPI transactions: channel select, then read-back. One channel is converted per nxt request, rotating lft -> rght -> batt -> lft.

Parameters:
- LFT_CH, 3'd0, A2D channel for the left load cell
- RGHT_CH, 3'd4, A2D channel for the right load cell
- BATT_CH, 3'd5, A2D channel for battery voltage

Ports:
- clk  input  1  50MHz system clock
- rst_n  input  1  asynchronous active-low reset
- nxt  input  1  request one conversion (level or pulse; sampled only in IDLE)
- done  input  1  SPI master transaction-complete pulse, 1 clk
- rd_data  input  16  SPI master receive data, valid when done=1
- wrt  output  1  start SPI transaction, 1-clk pulse
- cmd  output  16  SPI transmit word
- lft_ld  output  12  latest left load-cell result
- rght_ld  output  12  latest right load-cell result
- batt  output  12  latest battery result
- cnv_cmplt  output  1  1-clk pulse when any result register updates
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE, channel pointer=LFT, wrt=0, cmd=0, lft_ld=rght_ld=batt=0, cnv_cmplt=0. Reset mid-transaction abandons it; any later done pulse is ignored because the block is in IDLE.
- cmd for the channel select is {2'b00, ch[2:0], 11'h000}, where ch is selected by the pointer (0=LFT_CH, 1=RGHT_CH, 2=BATT_CH).
- cmd is registered, is loaded in the same cycle wrt is asserted, and holds stable until the next load.
- FSM states: IDLE, SEL, GAP, READ.
  - IDLE: if nxt, assert wrt for 1 clk with the channel-select cmd, go to SEL. Otherwise stay; done is ignored.
  - SEL: wait for done. rd_data is discarded. On done go to GAP.
  - GAP: exactly one idle clock; no wrt. Then assert wrt for 1 clk (cmd unchanged) and go to READ.
  - READ: wait for done. On done, capture rd_data[11:0] into the pointer's result register, pulse cnv_cmplt in the same cycle the register updates (1 clk after done), advance the pointer (2 wraps to 0), and return to IDLE.
- Result registers change only on capture; the two untouched channels hold their values.
- nxt while busy is ignored: no queueing.
- nxt held high starts a new conversion on the first IDLE cycle, giving back-to-back round robin.
- Minimum latency nxt -> cnv_cmplt = (SPI transaction 1) + (SPI transaction 2) + 4 clk of overhead.
- No timeout: if done never arrives, the FSM stays in SEL/READ until reset.
- Pointer value 3 is unreachable. If it occurs, treat it as 0.

Optional Feature:
- Macro LD_AVG_EN.
- Defined: lft_ld and rght_ld capture (old + new)>>1, computed as a 13-bit unsigned sum, bits [12:1].
  - The first capture after reset loads new directly, tracked by a per-channel first flag.
  - batt is always unfiltered.
- Undefined: direct capture of rd_data[11:0] for all channels; no flag logic.

Test Plan:
- Reset then nxt pulse; SPI model returns 16'hFABC on the read transaction -> cmd=16'h0000 on the first wrt; one GAP clk between wrts; lft_ld=12'hABC; cnv_cmplt pulses once; rght_ld=batt=0.
- Three nxt requests with read returns 12'h123, 12'h456, 12'h789 -> cmd channel fields 0, 4, 5; lft_ld=123, rght_ld=456, batt=789; 4th request selects channel 0 again.
- nxt held high for 4 conversions -> wrt pulses are exactly 1 clk; the next SEL starts the cycle after cnv_cmplt; the fourth conversion overwrites lft_ld only.
- nxt pulses during SEL and READ -> ignored; exactly one cnv_cmplt per accepted request.
- rst_n asserted during READ, then a spurious done -> all outputs 0, no capture, next nxt selects channel 0.
- LD_AVG_EN defined: left reads 12'h100 then 12'h201 -> lft_ld=100 then 180; undefined -> 100 then 201.
